// File: rtl/tt_mux_pg.sv
// Power-gated user-module mux for one row. It decodes the registered spine select,
// sequences the power switch, isolation and enable of the chosen module, and returns
// that module's outputs through a two-level output mux.
module tt_mux_pg #(
  parameter int N_UM    = 16,
  parameter int GRP     = 4,
  parameter int N_IO    = 8,
  parameter int N_O     = 8,
  parameter int N_I     = 10,
  parameter int PG_DLY  = 16,
  parameter int ISO_DLY = 4,
  parameter int OUT_REG = 1,
  localparam int U_OW   = N_O + 2 * N_IO,
  localparam int U_IW   = N_I + N_IO,
  localparam int N_GRP  = N_UM / GRP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             addr,
  input  logic [U_IW+9:0]        spine_iw,
  output logic [U_OW-1:0]        spine_ow,
  input  logic [U_OW*N_UM-1:0]   um_ow,
  output logic [U_IW*N_UM-1:0]   um_iw,
  output logic [N_UM-1:0]        um_ena,
  output logic [N_UM-1:0]        um_pwr_en,
  output logic                   busy,
  output logic [4:0]             cur_sel
);

  typedef enum logic [2:0] {IDLE, PWRUP, ISO, ACTIVE, PWRDN} state_t;

  localparam logic [7:0] PG_LD  = 8'(PG_DLY - 1);
  localparam logic [7:0] ISO_LD = 8'(ISO_DLY - 1);
  localparam logic [5:0] N_UM6  = 6'(N_UM);
  localparam logic [4:0] GRP5   = 5'(GRP);

  state_t            state;
  logic [7:0]        cnt;
  logic [4:0]        cur;
  logic [U_IW+9:0]   si_q;

  logic [U_IW-1:0]   si_usr;
  logic [3:0]        si_row;
  logic [4:0]        si_col;
  logic              si_ena;
  logic              tgt_vld;
  logic              tgt_chg;
  logic              pwr_on;
  logic              act;
  logic [4:0]        sub_idx;
  logic [4:0]        grp_idx;
  logic [U_OW-1:0]   grp_ow [N_GRP];
  logic [U_OW-1:0]   mux_ow;

  // Stage p0 -> p1: capture the spine every cycle; all decode works from this copy.
  always_ff @(posedge clk) begin
    if (rst) si_q <= '0;
    else     si_q <= spine_iw;
  end

  assign si_usr  = si_q[U_IW+9:10];
  assign si_row  = si_q[9:6];
  assign si_col  = si_q[5:1];
  assign si_ena  = si_q[0];
  assign tgt_vld = si_ena && (si_row == addr) && ({1'b0, si_col} < N_UM6);
  // Any difference from the latched module, including "none", forces a power-down.
  assign tgt_chg = !tgt_vld || (si_col != cur);

  // Power sequencer: each state loads the delay counter on entry and counts it down.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tgt_vld) begin
            cur   <= si_col;
            state <= PWRUP;
            cnt   <= PG_LD;
          end
        end
        PWRUP: begin
          if (tgt_chg) begin
            state <= PWRDN;
            cnt   <= ISO_LD;
          end else if (cnt == 8'd0) begin
            state <= ISO;
            cnt   <= ISO_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ISO: begin
          if (tgt_chg) begin
            state <= PWRDN;
            cnt   <= ISO_LD;
          end else if (cnt == 8'd0) begin
            state <= ACTIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACTIVE: begin
          if (tgt_chg) begin
            state <= PWRDN;
            cnt   <= ISO_LD;
          end
        end
        PWRDN: begin
          if (cnt == 8'd0) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign pwr_on  = (state != IDLE);
  assign act     = (state == ACTIVE);
  assign busy    = (state == PWRUP) || (state == ISO) || (state == PWRDN);
  assign cur_sel = (state == IDLE) ? 5'd0 : cur;

  // Per-module power, enable and input steering: only the latched module is touched.
  always_comb begin
    um_pwr_en = '0;
    um_ena    = '0;
    um_iw     = '0;
    for (int i = 0; i < N_UM; i++) begin
      if (pwr_on && (cur == 5'(i))) um_pwr_en[i] = 1'b1;
      if (act && (cur == 5'(i))) begin
        um_ena[i]               = 1'b1;
        um_iw[U_IW*i +: U_IW]   = si_usr;
      end
    end
  end

  assign sub_idx = cur % GRP5;
  assign grp_idx = cur / GRP5;

  // First mux level: same position picked inside every group.
  always_comb begin
    for (int g = 0; g < N_GRP; g++) begin
      grp_ow[g] = '0;
      for (int k = 0; k < GRP; k++) begin
        if (sub_idx == 5'(k)) grp_ow[g] = um_ow[U_OW*(g*GRP+k) +: U_OW];
      end
    end
  end

  // Second mux level across groups; forced to zero unless a module is active.
  always_comb begin
    mux_ow = '0;
    if (act) begin
      for (int g = 0; g < N_GRP; g++) begin
        if (grp_idx == 5'(g)) mux_ow = grp_ow[g];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [U_OW-1:0] spine_ow_p1;
      // Stage p1 -> p2: optional output register toward the spine.
      always_ff @(posedge clk) begin
        if (rst) spine_ow_p1 <= '0;
        else     spine_ow_p1 <= mux_ow;
      end
      assign spine_ow = spine_ow_p1;
    end else begin : g_out_comb
      assign spine_ow = mux_ow;
    end
  endgenerate

endmodule

// File: tb/tb_tt_mux_pg.sv
// Bench for tt_mux_pg: directed scenarios plus random target sequences, checked
// cycle by cycle against a behavioural model through an expectation queue.
module tb_tt_mux_pg;

  localparam int NUM = 16;
  localparam int UOW = 24;
  localparam int UIW = 18;
  localparam int SIW = UIW + 10;
  localparam int PG  = 8;
  localparam int ISO = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           addr;
  logic [SIW-1:0]       spine_iw;
  logic [UOW-1:0]       spine_ow;
  logic [UOW*NUM-1:0]   um_ow;
  logic [UIW*NUM-1:0]   um_iw;
  logic [NUM-1:0]       um_ena;
  logic [NUM-1:0]       um_pwr_en;
  logic                 busy;
  logic [4:0]           cur_sel;

  tt_mux_pg #(.N_UM(NUM), .GRP(4), .N_IO(8), .N_O(8), .N_I(10),
              .PG_DLY(PG), .ISO_DLY(ISO), .OUT_REG(1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .spine_iw(spine_iw), .spine_ow(spine_ow),
    .um_ow(um_ow), .um_iw(um_iw), .um_ena(um_ena), .um_pwr_en(um_pwr_en),
    .busy(busy), .cur_sel(cur_sel));

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM-1:0]     pwr;
    logic [NUM-1:0]     ena;
    logic [UIW*NUM-1:0] iw;
    logic               busy;
    logic [4:0]         cs;
    logic [UOW-1:0]     ow;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  logic [NUM-1:0]     h_pwr  [64];
  logic [NUM-1:0]     h_ena  [64];
  logic [UIW*NUM-1:0] h_iw   [64];
  logic [UOW-1:0]     h_ow   [64];
  logic               h_busy [64];
  logic [UOW*NUM-1:0] h_umow [64];

  task automatic chk(input string nm, input logic [UOW*NUM-1:0] act, input logic [UOW*NUM-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic int tgt_of(input logic [SIW-1:0] s);
    if (s[0] && (s[9:6] == 4'd3) && (s[5:1] < 5'd16)) return int'(s[5:1]);
    return -1;
  endfunction

  // Behavioural model: a powered module has an age since power-on; it is usable once
  // the age covers power settling plus isolation. A different target starts a drain
  // of ISO cycles, after which power is off for at least one cycle.
  initial begin : model
    int m_on, m_cur, m_age, m_down, t;
    logic [SIW-1:0] m_siq;
    logic [UOW-1:0] m_ow;
    bit act;
    exp_t e;
    m_on = 0; m_cur = 0; m_age = 0; m_down = -1; m_siq = '0; m_ow = '0;
    forever begin
      @(posedge clk);
      act = (m_on != 0) && (m_down < 0) && (m_age >= PG + ISO);
      if (rst) begin
        m_on = 0; m_down = -1; m_age = 0; m_siq = '0; m_ow = '0;
      end else begin
        m_ow = act ? um_ow[UOW*m_cur +: UOW] : '0;
        t = tgt_of(m_siq);
        if (m_on == 0) begin
          if (t >= 0) begin m_on = 1; m_cur = t; m_age = 0; m_down = -1; end
        end else if (m_down >= 0) begin
          if (m_down == ISO - 1) begin m_on = 0; m_down = -1; end
          else m_down++;
        end else if (t != m_cur) begin
          m_down = 0;
        end else if (m_age < 1000) begin
          m_age++;
        end
        m_siq = spine_iw;
      end
      act = (m_on != 0) && (m_down < 0) && (m_age >= PG + ISO);
      e.pwr  = (m_on != 0) ? (NUM'(1) << m_cur) : '0;
      e.ena  = act ? (NUM'(1) << m_cur) : '0;
      e.iw   = '0;
      if (act) e.iw[UIW*m_cur +: UIW] = m_siq[SIW-1:10];
      e.busy = (m_on != 0) && !act;
      e.cs   = (m_on != 0) ? 5'(m_cur) : 5'd0;
      e.ow   = m_ow;
      q.push_back(e);
    end
  end

  // Monitor: pop the expectation for this cycle and compare it with the DUT.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("um_pwr_en", um_pwr_en, e.pwr);
        chk("um_ena", um_ena, e.ena);
        chk("um_iw", um_iw, e.iw);
        chk("busy", busy, e.busy);
        chk("cur_sel", cur_sel, e.cs);
        chk("spine_ow", spine_ow, e.ow);
        chk("pwr_onehot", ($countones(um_pwr_en) <= 1), 1'b1);
        chk("ena_onehot", ($countones(um_ena) <= 1), 1'b1);
        chk("ena_implies_pwr", (um_ena & ~um_pwr_en), '0);
      end
    end
  end

  task automatic step(input logic r, input logic [3:0] row, input logic [4:0] col,
                      input logic ena, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = r;
      for (int w = 0; w < (UOW*NUM)/32; w++) um_ow[32*w +: 32] = $urandom();
      spine_iw = {18'($urandom()), row, col, ena};
      @(negedge clk);
      if (i < 64) begin
        h_pwr[i] = um_pwr_en; h_ena[i] = um_ena; h_iw[i] = um_iw;
        h_ow[i] = spine_ow; h_busy[i] = busy; h_umow[i] = um_ow;
      end
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, kind;
    logic [3:0] row;
    logic [4:0] col;
    logic ena;
    rst = 1'b1; addr = 4'd3; spine_iw = '0; um_ow = '0;
    step(1'b1, 4'd0, 5'd0, 1'b0, 4);
    chk("reset_pwr", h_pwr[3], '0);
    chk("reset_busy", h_busy[3], 1'b0);
    step(1'b0, 4'd0, 5'd0, 1'b0, 3);

    // Select row 3 column 5 and follow the power-up sequence.
    step(1'b0, 4'd3, 5'd5, 1'b1, 20);
    chk("sel5_pwr_c1", h_pwr[1], '0);
    chk("sel5_pwr_c2", h_pwr[2], 16'h0020);
    chk("sel5_ena_c11", h_ena[11], '0);
    chk("sel5_ena_c12", h_ena[12], 16'h0020);
    chk("sel5_ow_c13", h_ow[13], h_umow[12][UOW*5 +: UOW]);

    // Switch to column 9 while active.
    step(1'b0, 4'd3, 5'd9, 1'b1, 20);
    chk("sw9_ena_c1", h_ena[1], 16'h0020);
    chk("sw9_ena_c2", h_ena[2], '0);
    chk("sw9_pwr_c3", h_pwr[3], 16'h0020);
    chk("sw9_pwr_c4", h_pwr[4], '0);
    chk("sw9_pwr_c5", h_pwr[5], 16'h0200);

    // Non-matching selects keep everything off.
    step(1'b0, 4'd3, 5'd9, 1'b0, 10);
    step(1'b0, 4'd2, 5'd5, 1'b1, 8);
    for (int i = 0; i < 8; i++) chk("row2_pwr", h_pwr[i], '0);
    step(1'b0, 4'd3, 5'd20, 1'b1, 8);
    for (int i = 0; i < 8; i++) chk("col20_pwr", h_pwr[i], '0);
    step(1'b0, 4'd3, 5'd5, 1'b0, 8);
    for (int i = 0; i < 8; i++) chk("noena_busy", h_busy[i], 1'b0);

    // Abort during power-up, then the new column runs its full sequence.
    step(1'b0, 4'd3, 5'd7, 1'b1, 4);
    for (int i = 0; i < 4; i++) chk("abort_ena_old", h_ena[i], '0);
    step(1'b0, 4'd3, 5'd11, 1'b1, 30);
    for (int i = 0; i < 5; i++) chk("abort_ena_old2", h_ena[i], '0);
    chk("abort_new_ena_c14", h_ena[14], '0);
    chk("abort_new_ena_c15", h_ena[15], 16'h0800);

    // Reset while active clears every output after one edge.
    step(1'b1, 4'd3, 5'd11, 1'b1, 2);
    chk("rst_act_pwr", h_pwr[1], '0);
    chk("rst_act_ena", h_ena[1], '0);
    chk("rst_act_iw", h_iw[1], '0);
    chk("rst_act_ow", h_ow[1], '0);
    chk("rst_act_busy", h_busy[1], 1'b0);
    step(1'b0, 4'd3, 5'd11, 1'b1, 20);

    // Random target sequences with occasional resets.
    for (int s = 0; s < 150; s++) begin
      n = int'($urandom_range(1, 20));
      kind = int'($urandom_range(0, 99));
      row = 4'd3; ena = 1'b1; col = 5'($urandom_range(0, 15));
      if (kind < 3) begin
        step(1'b1, row, col, ena, int'($urandom_range(1, 3)));
        continue;
      end else if (kind < 13) col = 5'($urandom_range(16, 31));
      else if (kind < 23) row = 4'($urandom);
      else if (kind < 33) ena = 1'b0;
      step(1'b0, row, col, ena, n);
    end
    step(1'b0, 4'd0, 5'd0, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
